regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_pkg.sv | 10 +
 rtl/regfile_scoreboard_if.sv | 38 +++
 rtl/regfile_scoreboard.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared defaults and register-index type for the scoreboarded register file
package regfile_scoreboard_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;

  // Index type shared with instruction decode so operand fields match the file depth.
  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write/reserve bundle between a pipeline and the register file
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              busy_a;
  logic              busy_b;
  logic [DEPTH-1:0]  busy_vec;

  modport master (
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, busy_vec
  );

  modport slave (
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - two-read one-write register file with per-register pending (scoreboard) bits
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  regfile_scoreboard_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DATA_W-1:0] rd_q_a;
  logic [DATA_W-1:0] rd_q_b;
  logic [DATA_W-1:0] rd_nxt_a;
  logic [DATA_W-1:0] rd_nxt_b;
  logic              wr_ok;
  logic              rsv_ok;
  logic              fwd_a;
  logic              fwd_b;

  // With a hardwired zero register, index 0 never accepts data nor a reservation.
  always_comb begin
    wr_ok  = bus.wr_en  && !(ZERO_REG && (bus.wr_addr  == '0));
    rsv_ok = bus.rsv_en && !(ZERO_REG && (bus.rsv_addr == '0));
    fwd_a  = BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr_a);
    fwd_b  = BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr_b);
  end

  always_comb begin
    rd_nxt_a = regs[bus.rd_addr_a];
    if (ZERO_REG && (bus.rd_addr_a == '0)) begin
      rd_nxt_a = '0;
    end else if (fwd_a) begin
      rd_nxt_a = bus.wr_data;
    end
  end

  always_comb begin
    rd_nxt_b = regs[bus.rd_addr_b];
    if (ZERO_REG && (bus.rd_addr_b == '0)) begin
      rd_nxt_b = '0;
    end else if (fwd_b) begin
      rd_nxt_b = bus.wr_data;
    end
  end

  // Reserve is applied after the write-clear so a new producer stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[bus.wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  // A value being written this cycle is not a hazard unless it is re-reserved at once.
  always_comb begin
    bus.busy_a = busy_q[bus.rd_addr_a] &&
                 !(fwd_a && !(rsv_ok && (bus.rsv_addr == bus.rd_addr_a)));
    bus.busy_b = busy_q[bus.rd_addr_b] &&
                 !(fwd_b && !(rsv_ok && (bus.rsv_addr == bus.rd_addr_b)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      rd_q_a <= '0;
      rd_q_b <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) begin
        regs[bus.wr_addr] <= bus.wr_data;
      end
      if (bus.rd_en_a) begin
        rd_q_a <= rd_nxt_a;
      end
      if (bus.rd_en_b) begin
        rd_q_b <= rd_nxt_b;
      end
      busy_q <= busy_d;
    end
  end

  assign bus.rd_data_a = rd_q_a;
  assign bus.rd_data_b = rd_q_b;
  assign bus.busy_vec  = busy_q;

endmodule
